// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: sequencer for the EX-stage iterative divide (DIV/DIVU).
// Radix-2 restoring divide, one quotient bit per cycle, result {remainder, quotient}.
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the divide
// finishes two edges after the request instead of running all DATA_W iterations.
module ex_div_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   dividend;   // |dividend| shifted out, quotient bits shifted in
    logic [DATA_W-1:0]   divisor;    // |divisor|
    logic [DATA_W-1:0]   rem;        // partial remainder, always < divisor
    logic                neg_quot;
    logic                neg_rem;

    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic                early_out;

    logic [DATA_W:0]     partial;
    logic [DATA_W:0]     diff;
    logic                ge;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quot_next;

    // Conditional two's-complement negation of remainder and quotient.
    function automatic logic [2*DATA_W-1:0] sign_fix(
        input logic [DATA_W-1:0] r,
        input logic [DATA_W-1:0] q,
        input logic              nr,
        input logic              nq
    );
        logic [DATA_W-1:0] rf;
        logic [DATA_W-1:0] qf;
        rf = nr ? ('0 - r) : r;
        qf = nq ? ('0 - q) : q;
        return {rf, qf};
    endfunction

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    // Operand magnitudes and sign flags for the request currently on the inputs.
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_abs = op1_neg ? ('0 - opdata1_i) : opdata1_i;
        op2_abs = op2_neg ? ('0 - opdata2_i) : opdata2_i;
    end

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (op1_abs < op2_abs);
`else
    assign early_out = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // Since rem < divisor, the top bit of diff is the borrow of the trial subtract.
    always_comb begin
        partial   = {rem, dividend[DATA_W-1]};
        diff      = partial - {1'b0, divisor};
        ge        = ~diff[DATA_W];
        rem_next  = ge ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
        quot_next = {dividend[DATA_W-2:0], ge};
    end

    // Divide sequencer with registered ready/result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        cnt <= '0;
                        if (opdata2_i == '0) begin
                            // Divide by zero: zero operands so the result is 0.
                            state    <= ST_BYZERO;
                            dividend <= '0;
                            divisor  <= '0;
                            rem      <= '0;
                            neg_quot <= 1'b0;
                            neg_rem  <= 1'b0;
                        end else if (early_out) begin
                            // Early-out shares the one-cycle BYZERO path: quotient 0,
                            // remainder |dividend|, sign fix restores the original dividend.
                            state    <= ST_BYZERO;
                            dividend <= '0;
                            divisor  <= op2_abs;
                            rem      <= op1_abs;
                            neg_quot <= op1_neg ^ op2_neg;
                            neg_rem  <= op1_neg;
                        end else begin
                            state    <= ST_ON;
                            dividend <= op1_abs;
                            divisor  <= op2_abs;
                            rem      <= '0;
                            neg_quot <= op1_neg ^ op2_neg;
                            neg_rem  <= op1_neg;
                        end
                    end
                end

                ST_BYZERO: begin
                    if (annul_i || !start_i) begin
                        state <= ST_FREE;
                        cnt   <= '0;
                    end else begin
                        state    <= ST_END;
                        ready_o  <= 1'b1;
                        result_o <= sign_fix(rem, dividend, neg_rem, neg_quot);
                    end
                end

                ST_ON: begin
                    if (annul_i || !start_i) begin
                        state <= ST_FREE;
                        cnt   <= '0;
                    end else begin
                        rem      <= rem_next;
                        dividend <= quot_next;
                        cnt      <= cnt + 1'b1;
                        // The last iteration and the sign fix land on the same edge.
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state    <= ST_END;
                            ready_o  <= 1'b1;
                            result_o <= sign_fix(rem_next, quot_next, neg_rem, neg_quot);
                        end
                    end
                end

                ST_END: begin
                    if (!start_i || annul_i) begin
                        state    <= ST_FREE;
                        cnt      <= '0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end

                default: begin
                    state    <= ST_FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed checks of the EX divide sequencer.
// Expected latencies depend on the DIV_EARLY_OUT_EN build macro.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int failures = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SHORT_LAT = 2;
`else
    localparam int SHORT_LAT = 33;
`endif

    ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Raise start_i with the given operands right after an edge (edge T), then
    // count edges until ready_o and stall cycles seen along the way.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [63:0] exp_res, input logic scramble);
        int lat;
        int stall;
        bit got;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        lat   = 0;
        stall = 0;
        got   = 1'b0;
        #1;
        for (int i = 0; i < 100 && !got; i++) begin
            if (stallreq_o) stall++;
            edge1();
            lat++;
            if (scramble) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
            if (ready_o) got = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall"}, 64'(stall), 64'(exp_lat));
        check({tag, "_result"}, result_o, exp_res);
    endtask

    task automatic drop_start(input string tag);
        start_i = 1'b0;
        edge1();
        check({tag, "_drop_ready"}, {63'b0, ready_o}, 64'd0);
        check({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        int ready_seen;

        // Reset state
        repeat (2) edge1();
        check("reset_ready", {63'b0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", {63'b0, stallreq_o}, 64'd0);
        rst = 1'b1;
        edge1();

        // DIVU 100/7, operands scrambled after acceptance, result held while start_i stays high
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b1);
        repeat (3) edge1();
        check("hold_ready", {63'b0, ready_o}, 64'd1);
        check("hold_result", result_o, {32'd2, 32'd14});
        drop_start("divu_100_7");
        edge1();

        // DIV -7/2
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        drop_start("div_m7_2");

        // DIV 0x80000000 / -1 wraps
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, 1'b0);
        drop_start("div_min_m1");

        // DIVU 5/0 and DIV -5/0
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 64'd0, 1'b0);
        drop_start("divu_5_0");
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, 64'd0, 1'b0);
        drop_start("div_m5_0");

        // Annul at iteration 10, then the held request re-accepts 9/3
        signed_div_i = 1'b0;
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'd1;
        start_i = 1'b1;
        edge1();
        ready_seen = 0;
        for (int i = 0; i < 10; i++) begin
            edge1();
            if (ready_o) ready_seen++;
        end
        annul_i = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        #1;
        check("annul_stall", {63'b0, stallreq_o}, 64'd0);
        edge1();
        if (ready_o) ready_seen++;
        check("annul_no_ready", 64'(ready_seen), 64'd0);
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 1'b0);
        drop_start("after_annul_9_3");

        // Asynchronous reset mid-divide, then 12/4 runs normally
        signed_div_i = 1'b0;
        opdata1_i = 32'h0001_2345;
        opdata2_i = 32'd16;
        start_i = 1'b1;
        edge1();
        repeat (20) edge1();
        #2;
        rst = 1'b0;
        #1;
        check("rst_on_ready", {63'b0, ready_o}, 64'd0);
        check("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        edge1();
        rst = 1'b1;
        edge1();
        run_div("after_rst_12_4", 1'b0, 32'd12, 32'd4, 33, {32'd0, 32'd3}, 1'b0);

        // Asynchronous reset while holding a result clears it at once
        #2;
        rst = 1'b0;
        #1;
        check("rst_end_ready", {63'b0, ready_o}, 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        edge1();
        rst = 1'b1;
        edge1();

        // Small dividend: early-out build finishes at T+2, otherwise full length
        run_div("div_3_m8", 1'b1, 32'd3, 32'hFFFF_FFF8, SHORT_LAT, {32'd3, 32'd0}, 1'b0);
        drop_start("div_3_m8");
        run_div("div_m3_8", 1'b1, 32'hFFFF_FFFD, 32'd8, SHORT_LAT, {32'hFFFF_FFFD, 32'd0}, 1'b0);
        drop_start("div_m3_8");
        run_div("divu_7_9", 1'b0, 32'd7, 32'd9, SHORT_LAT, {32'd7, 32'd0}, 1'b0);
        drop_start("divu_7_9");

        // Full-width unsigned divide
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd10, 33, {32'd5, 32'h1999_9999}, 1'b0);
        drop_start("divu_big");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
